// File: rtl/distortion_pkg.sv
// Shared types and helpers for the serial stereo distortion stage.
package distortion_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    HARD   = 2'd1,
    ASYM   = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SAT_MAX_W = 64;

  // Clamp a sign-extended value to the range of a w-bit two's complement word.
  function automatic logic signed [SAT_MAX_W-1:0] saturate(
    input logic signed [SAT_MAX_W-1:0] p,
    input int unsigned                 w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'd1));
    if (p > hi) begin
      saturate = hi;
    end else if (p < lo) begin
      saturate = lo;
    end else begin
      saturate = p;
    end
  endfunction

endpackage

// File: rtl/distortion_clip_core.sv
// Combinational single-channel clip -> multiply -> saturate slice,
// time-shared across the channels of a frame.
module distortion_clip_core
  import distortion_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 8
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic        [DATA_W-2:0] t,
  input  logic        [GAIN_W-1:0] g,
  input  logic        [1:0]        mode,
  output logic signed [DATA_W-1:0] y
);

  // Wide enough that neither -t nor c*g can overflow.
  localparam int PW = DATA_W + GAIN_W + 1;

  logic signed [PW-1:0] x_s;
  logic signed [PW-1:0] t_s;
  logic signed [PW-1:0] g_s;
  logic signed [PW-1:0] c_s;
  logic signed [PW-1:0] p_s;

  // Clip, scale and saturate one sample; mode 3 falls into the hard-clip path.
  always_comb begin
    x_s = {{(PW-DATA_W){x[DATA_W-1]}}, x};
    t_s = {{(PW-DATA_W+1){1'b0}}, t};
    g_s = {{(PW-GAIN_W){1'b0}}, g};
    c_s = x_s;
    case (mode)
      BYPASS: begin
        c_s = x_s;
      end
      ASYM: begin
        if (x_s > t_s) begin
          c_s = t_s;
        end else begin
          c_s = x_s;
        end
      end
      default: begin
        if (x_s > t_s) begin
          c_s = t_s;
        end else if (x_s < -t_s) begin
          c_s = -t_s;
        end else begin
          c_s = x_s;
        end
      end
    endcase
    p_s = c_s * g_s;
    if (mode == BYPASS) begin
      y = x;
    end else begin
      y = DATA_W'(saturate({{(SAT_MAX_W-PW){p_s[PW-1]}}, p_s}, DATA_W));
    end
  end

endmodule

// File: rtl/distortion_stream.sv
// Frame-based distortion stage: accepts CHANNELS samples per handshake and
// runs them one per cycle through a shared clip core, with per-frame gain ramp.
module distortion_stream
  import distortion_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CHANNELS  = 2,
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_samples,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_samples,
  input  logic [GAIN_W-1:0]            gain,
  input  logic [DATA_W-2:0]            threshold,
  input  logic [1:0]                   mode,
  output logic [GAIN_W-1:0]            gain_cur
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [GAIN_W:0]   STEP_V   = (GAIN_W + 1)'(RAMP_STEP);

  state_t                     state_r;
  state_t                     state_nx_s;
  logic [IDX_W-1:0]           idx_r;
  logic [CHANNELS*DATA_W-1:0] frame_r;
  logic [CHANNELS*DATA_W-1:0] out_r;
  logic [DATA_W-2:0]          thr_r;
  logic [1:0]                 mode_r;
  logic [GAIN_W-1:0]          gain_cur_r;
  logic [GAIN_W-1:0]          gain_nx_s;
  logic [GAIN_W:0]            diff_s;
  logic                       in_ready_r;
  logic                       out_valid_r;
  logic                       accept_s;
  logic signed [DATA_W-1:0]   x_s;
  logic signed [DATA_W-1:0]   y_s;

  // Next-state decode for the accept / process / hold sequence.
  always_comb begin
    accept_s   = in_valid && in_ready_r;
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = PROC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      PROC: begin
        if (idx_r == LAST_IDX) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = PROC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Gain to apply to the frame being accepted: step toward target, never past it.
  always_comb begin
    gain_nx_s = gain_cur_r;
    diff_s    = '0;
    if (STEP_V == '0) begin
      gain_nx_s = gain;
    end else if (gain > gain_cur_r) begin
      diff_s = {1'b0, gain} - {1'b0, gain_cur_r};
      if (diff_s > STEP_V) begin
        gain_nx_s = gain_cur_r + STEP_V[GAIN_W-1:0];
      end else begin
        gain_nx_s = gain;
      end
    end else begin
      diff_s = {1'b0, gain_cur_r} - {1'b0, gain};
      if (diff_s > STEP_V) begin
        gain_nx_s = gain_cur_r - STEP_V[GAIN_W-1:0];
      end else begin
        gain_nx_s = gain;
      end
    end
  end

  // Channel currently in the shared datapath.
  always_comb begin
    x_s = frame_r[idx_r*DATA_W +: DATA_W];
  end

  distortion_clip_core #(
    .DATA_W (DATA_W),
    .GAIN_W (GAIN_W)
  ) u_clip_core (
    .x    (x_s),
    .t    (thr_r),
    .g    (gain_cur_r),
    .mode (mode_r),
    .y    (y_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Frame capture, per-channel result write-back and registered handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r       <= '0;
      frame_r     <= '0;
      out_r       <= '0;
      thr_r       <= '0;
      mode_r      <= 2'd0;
      gain_cur_r  <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
      if (accept_s) begin
        frame_r    <= in_samples;
        thr_r      <= threshold;
        mode_r     <= mode;
        gain_cur_r <= gain_nx_s;
        idx_r      <= '0;
      end else if (state_r == PROC) begin
        out_r[idx_r*DATA_W +: DATA_W] <= y_s;
        idx_r                         <= idx_r + 1'b1;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_samples = out_r;
  assign gain_cur    = gain_cur_r;

endmodule

// File: tb/tb_distortion_stream.sv
// Directed bench for distortion_stream: two instances (immediate gain, ramped gain)
// share stimulus and are checked every cycle against a frame-level model.
module tb_distortion_stream;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int GW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [CH*DW-1:0] in_samples = '0;
  logic [GW-1:0]   gain = '0;
  logic [DW-2:0]   threshold = '0;
  logic [1:0]      mode = 2'd0;

  logic            ir [2];
  logic            ov [2];
  logic [CH*DW-1:0] os [2];
  logic [GW-1:0]   gc [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  distortion_stream #(.DATA_W(DW), .CHANNELS(CH), .GAIN_W(GW), .RAMP_STEP(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .in_samples(in_samples), .out_valid(ov[0]), .out_ready(out_ready),
    .out_samples(os[0]), .gain(gain), .threshold(threshold), .mode(mode),
    .gain_cur(gc[0])
  );

  distortion_stream #(.DATA_W(DW), .CHANNELS(CH), .GAIN_W(GW), .RAMP_STEP(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .in_samples(in_samples), .out_valid(ov[1]), .out_ready(out_ready),
    .out_samples(os[1]), .gain(gain), .threshold(threshold), .mode(mode),
    .gain_cur(gc[1])
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: plain integer arithmetic straight from the mode rules.
  function automatic int ref_y(input int x, input int t, input int g, input int md);
    int c;
    int p;
    if (md == 0) return x;
    c = x;
    if (c > t) c = t;
    else if (md != 2 && c < -t) c = -t;
    p = c * g;
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
  endfunction

  function automatic int ramp(input int cur, input int tgt, input int step);
    if (step == 0) return tgt;
    if (tgt - cur > step) return cur + step;
    if (cur - tgt > step) return cur - step;
    return tgt;
  endfunction

  function automatic logic [CH*DW-1:0] pk(input int a, input int b);
    logic [DW-1:0] la;
    logic [DW-1:0] lb;
    la = DW'(a);
    lb = DW'(b);
    return {lb, la};
  endfunction

  function automatic int smp(input int inst, input int c);
    return int'($signed(os[inst][c*DW +: DW]));
  endfunction

  // Model state per instance (index = RAMP_STEP of that instance).
  int m_rdy [2];
  int m_vld [2];
  int m_gain [2];
  int m_cnt [2];
  int m_known [2];
  int m_out [2][CH];
  int m_pend [2][CH];
  bit started = 1'b0;

  // Advance the model on each active edge from the inputs held stable across it.
  always @(posedge clk) begin
    started = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_rdy[i] = 1; m_vld[i] = 0; m_gain[i] = 0; m_cnt[i] = 0; m_known[i] = 1;
        for (int c = 0; c < CH; c++) m_out[i][c] = 0;
      end else if (m_cnt[i] > 0) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          for (int c = 0; c < CH; c++) m_out[i][c] = m_pend[i][c];
          m_vld[i] = 1;
          m_known[i] = 1;
        end
      end else if (m_vld[i] != 0) begin
        if (out_ready) begin
          m_vld[i] = 0;
          m_rdy[i] = 1;
        end
      end else if (in_valid) begin
        m_gain[i] = ramp(m_gain[i], int'(gain), i);
        for (int c = 0; c < CH; c++)
          m_pend[i][c] = ref_y(int'($signed(in_samples[c*DW +: DW])), int'(threshold), m_gain[i], int'(mode));
        m_cnt[i] = CH;
        m_rdy[i] = 0;
        m_known[i] = 0;
      end
    end
  end

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dut%0d.in_ready", i), ir[i], m_rdy[i]);
        chk($sformatf("dut%0d.out_valid", i), ov[i], m_vld[i]);
        chk($sformatf("dut%0d.gain_cur", i), gc[i], m_gain[i]);
        if (m_known[i] != 0) begin
          for (int c = 0; c < CH; c++)
            chk($sformatf("dut%0d.out_samples[%0d]", i, c), smp(i, c), m_out[i][c]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Offer one frame; return in the cycle dut0 raises out_valid (lat counted from accept).
  task automatic run_frame(input int a, input int b, output int lat);
    in_samples = pk(a, b);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 10) begin
      step();
      lat++;
    end
  endtask

  task automatic frame_chk(input string name, input int inst, input int a, input int b,
                           input int ea, input int eb);
    int lat;
    run_frame(a, b, lat);
    chk({name, "_latency"}, lat, 3);
    chk({name, "_ch0"}, smp(inst, 0), ea);
    chk({name, "_ch1"}, smp(inst, 1), eb);
    step();
  endtask

  int lat;
  int exp_o [4] = '{10, 20, 30, 30};
  int exp_g [4] = '{1, 2, 3, 3};
  int bmode [4] = '{1, 2, 1, 3};
  int bthr  [4] = '{0, 50, 32767, 50};
  int bgain [4] = '{10, 0, 1, 10};
  int ba    [4] = '{100, 100, -32768, 100};
  int bb    [4] = '{-100, -100, 32767, -100};
  int bea   [4] = '{0, 0, -32767, 500};
  int beb   [4] = '{0, 0, 32767, -500};

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("reset_in_ready", ir[0], 1);
    chk("reset_out_valid", ov[0], 0);

    // Model pins against hand-computed values.
    chk("model_hard", ref_y(100, 50, 10, 1), 500);
    chk("model_asym_neg", ref_y(-100, 50, 10, 2), -1000);
    chk("model_sat", ref_y(-20000, 20000, 200, 1), -32768);

    mode = 2'd1; threshold = 15'd50; gain = 8'd10;
    frame_chk("t1", 0, 30, -30, 300, -300);
    frame_chk("t2a", 0, 100, -100, 500, -500);
    gain = 8'd200; threshold = 15'd20000;
    frame_chk("t2b", 0, 20000, -20000, 32767, -32768);

    mode = 2'd2; threshold = 15'd50; gain = 8'd10;
    frame_chk("t3_asym", 0, 100, -100, 500, -1000);
    mode = 2'd0;
    frame_chk("t3_bypass", 0, 12345, -32768, 12345, -32768);

    for (int k = 0; k < 4; k++) begin
      mode = 2'(bmode[k]); threshold = 15'(bthr[k]); gain = 8'(bgain[k]);
      frame_chk($sformatf("bound%0d", k), 0, ba[k], bb[k], bea[k], beb[k]);
    end

    // Backpressure: hold the finished frame while a new one is offered.
    mode = 2'd1; threshold = 15'd50; gain = 8'd10;
    out_ready = 1'b0;
    run_frame(100, -100, lat);
    chk("t4_latency", lat, 3);
    in_samples = pk(7, 7);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t4_hold_valid", ov[0], 1);
      chk("t4_hold_ready", ir[0], 0);
      chk("t4_hold_ch0", smp(0, 0), 500);
      chk("t4_hold_ch1", smp(0, 1), -500);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t4_release_ready", ir[0], 1);
    chk("t4_release_valid", ov[0], 0);

    // Ramp from zero on the RAMP_STEP=1 instance.
    do_reset();
    mode = 2'd1; threshold = 15'd50; gain = 8'd3;
    for (int k = 0; k < 4; k++) begin
      run_frame(10, 10, lat);
      chk("t5_latency", lat, 3);
      chk("t5_ramp_out", smp(1, 0), exp_o[k]);
      chk("t5_ramp_gain", gc[1], exp_g[k]);
      chk("t5_jump_out", smp(0, 1), 30);
      step();
    end

    // Reset while the frame is in PROC.
    gain = 8'd10;
    in_samples = pk(30, -30);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_gain0", gc[0], 0);
    chk("t6_gain1", gc[1], 0);
    for (int k = 0; k < 4; k++) begin
      chk("t6_no_valid", ov[0], 0);
      step();
    end
    frame_chk("t6_next", 0, 30, -30, 300, -300);
    chk("t6_next_ramped", gc[1], 1);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
